// File: rtl/auth_initiator.sv
// Authentication initiator: builds GET_DIGESTS / GET_CERTIFICATE / CHALLENGE requests,
// waits for the responder under a timeout, validates the reply and retries on timeout or Busy.
module auth_initiator #(
    parameter int unsigned MSG_LEN          = 256,
    parameter int unsigned TIMEOUT_CYCLES   = 1000,
    parameter int unsigned MAX_RETRIES      = 3,
    parameter int unsigned PROTOCOL_VERSION = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         req_type,
    input  logic [7:0]         req_param1,
    input  logic [7:0]         req_param2,
    input  logic [MSG_LEN-33:0] req_payload,
    output logic               init_req_out,
    output logic [MSG_LEN-1:0] auth_msg_init_out,
    input  logic               resp_valid_in,
    input  logic [MSG_LEN-1:0] auth_msg_resp_in,
    output logic               Ack_out,
    output logic               busy,
    output logic               done,
    output logic [2:0]         status,
    output logic [7:0]         resp_err_code,
    output logic [31:0]        resp_header,
    output logic [MSG_LEN-33:0] resp_payload
);

    localparam int unsigned PL = MSG_LEN - 32;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [7:0]    PV        = 8'(PROTOCOL_VERSION);

    localparam logic [2:0] ST_OK          = 3'd0;
    localparam logic [2:0] ST_TIMEOUT     = 3'd1;
    localparam logic [2:0] ST_BAD_VERSION = 3'd2;
    localparam logic [2:0] ST_BAD_TYPE    = 3'd3;
    localparam logic [2:0] ST_RESP_ERROR  = 3'd4;
    localparam logic [2:0] ST_BUSY_EXH    = 3'd5;
    localparam logic [2:0] ST_ILLEGAL     = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_RESP, S_CHECK, S_GAP, S_FINISH
    } state_t;

    state_t            state_q;
    logic [1:0]        type_q;
    logic [7:0]        p1_q, p2_q;
    logic [PL-1:0]     payload_q;
    logic [RW-1:0]     retry_cnt_q;
    logic [TW-1:0]     timeout_cnt_q;
    logic              init_q, ack_q, busy_q, done_q;
    logic [MSG_LEN-1:0] msg_q;
    logic [2:0]        status_q;
    logic [7:0]        err_q;
    logic [31:0]       hdr_q;
    logic [PL-1:0]     rpay_q;
    logic              can_retry;

    function automatic logic [7:0] req_code(input logic [1:0] t);
        return 8'h81 + {6'b0, t};
    endfunction

    function automatic logic [MSG_LEN-1:0] build_msg(input logic [1:0] t, input logic [7:0] a,
                                                     input logic [7:0] b, input logic [PL-1:0] pl);
        return {PV, req_code(t), a, b, pl};
    endfunction

    assign can_retry = (retry_cnt_q < RETRY_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            type_q        <= '0;
            p1_q          <= '0;
            p2_q          <= '0;
            payload_q     <= '0;
            retry_cnt_q   <= '0;
            timeout_cnt_q <= '0;
            init_q        <= 1'b0;
            ack_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            msg_q         <= '0;
            status_q      <= '0;
            err_q         <= '0;
            hdr_q         <= '0;
            rpay_q        <= '0;
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        type_q      <= req_type;
                        p1_q        <= req_param1;
                        p2_q        <= req_param2;
                        payload_q   <= req_payload;
                        retry_cnt_q <= '0;
                        status_q    <= ST_OK;
                        err_q       <= '0;
                        busy_q      <= 1'b1;
                        if (req_type == 2'd3) begin
                            status_q <= ST_ILLEGAL;
                            state_q  <= S_FINISH;
                        end else begin
                            // request goes out on entry to SEND so it is visible the cycle after start
                            msg_q   <= build_msg(req_type, req_param1, req_param2, req_payload);
                            init_q  <= 1'b1;
                            state_q <= S_SEND;
                        end
                    end
                end
                S_SEND: begin
                    timeout_cnt_q <= '0;
                    state_q       <= S_WAIT_RESP;
                end
                S_WAIT_RESP: begin
                    if (resp_valid_in) begin
                        hdr_q   <= auth_msg_resp_in[MSG_LEN-1 -: 32];
                        rpay_q  <= auth_msg_resp_in[PL-1:0];
                        ack_q   <= 1'b1;
                        init_q  <= 1'b0;
                        msg_q   <= '0;
                        state_q <= S_CHECK;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        // SEND cycle counts towards the window, so terminal count is one early here
                        if (timeout_cnt_q == TO_LAST) begin
                            init_q <= 1'b0;
                            if (can_retry) begin
                                retry_cnt_q <= retry_cnt_q + 1'b1;
                                state_q     <= S_GAP;
                            end else begin
                                status_q <= ST_TIMEOUT;
                                state_q  <= S_FINISH;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    state_q <= S_FINISH;
                    if (hdr_q[31:24] != PV) begin
                        status_q <= ST_BAD_VERSION;
                    end else if (hdr_q[23:16] == 8'h7F && hdr_q[15:8] == 8'h03) begin
                        if (can_retry) begin
                            retry_cnt_q <= retry_cnt_q + 1'b1;
                            state_q     <= S_GAP;
                        end else begin
                            status_q <= ST_BUSY_EXH;
                        end
                    end else if (hdr_q[23:16] == 8'h7F) begin
                        status_q <= ST_RESP_ERROR;
                        err_q    <= hdr_q[15:8];
                    end else if (hdr_q[23:16] == (req_code(type_q) & 8'h7F)) begin
                        status_q <= ST_OK;
                    end else begin
                        status_q <= ST_BAD_TYPE;
                    end
                end
                S_GAP: begin
                    msg_q   <= build_msg(type_q, p1_q, p2_q, payload_q);
                    init_q  <= 1'b1;
                    state_q <= S_SEND;
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign init_req_out      = init_q;
    assign auth_msg_init_out = msg_q;
    assign Ack_out           = ack_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign status            = status_q;
    assign resp_err_code     = err_q;
    assign resp_header       = hdr_q;
    assign resp_payload      = rpay_q;

endmodule

// File: tb/tb_auth_initiator.sv
// Bench for auth_initiator: directed vector table, hand sequences for reset/ignored inputs,
// then randomized transactions checked against an attempt-level reference model.
module tb_auth_initiator;

    localparam int unsigned ML = 256;
    localparam int unsigned PL = ML - 32;
    localparam int unsigned TO = 8;
    localparam int unsigned MR = 2;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [1:0]    req_type;
    logic [7:0]    req_param1, req_param2;
    logic [PL-1:0] req_payload;
    logic          init_req_out;
    logic [ML-1:0] auth_msg_init_out;
    logic          resp_valid_in;
    logic [ML-1:0] auth_msg_resp_in;
    logic          Ack_out, busy, done;
    logic [2:0]    status;
    logic [7:0]    resp_err_code;
    logic [31:0]   resp_header;
    logic [PL-1:0] resp_payload;

    int nvec  = 0;
    int nfail = 0;

    auth_initiator #(
        .MSG_LEN(ML), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .PROTOCOL_VERSION(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .req_type(req_type),
        .req_param1(req_param1), .req_param2(req_param2), .req_payload(req_payload),
        .init_req_out(init_req_out), .auth_msg_init_out(auth_msg_init_out),
        .resp_valid_in(resp_valid_in), .auth_msg_resp_in(auth_msg_resp_in),
        .Ack_out(Ack_out), .busy(busy), .done(done), .status(status),
        .resp_err_code(resp_err_code), .resp_header(resp_header), .resp_payload(resp_payload)
    );

    always #5 clk = ~clk;

    // dly[a]: cycles after init_req_out rises before answering attempt a (8'hFF = never)
    typedef struct packed {
        logic [1:0]         rtype;
        logic [7:0]         p1;
        logic [7:0]         p2;
        logic [PL-1:0]      pay;
        logic [0:2][7:0]    dly;
        logic [0:2][31:0]   hdr;
        logic [2:0]         e_status;
        logic [7:0]         e_err;
        logic [31:0]        e_hdr;
        logic [7:0]         e_att;
        logic [7:0]         e_acks;
        logic [7:0]         e_done;
    } vec_t;

    vec_t tbl [9];

    function automatic vec_t mk(input logic [1:0] t, input logic [7:0] p1, input logic [7:0] p2,
                                input logic [PL-1:0] pay, input logic [0:2][7:0] d,
                                input logic [0:2][31:0] h, input logic [2:0] es, input logic [7:0] ee,
                                input logic [31:0] eh, input int ea, input int eack, input int edone);
        vec_t v;
        v.rtype = t; v.p1 = p1; v.p2 = p2; v.pay = pay; v.dly = d; v.hdr = h;
        v.e_status = es; v.e_err = ee; v.e_hdr = eh;
        v.e_att = 8'(ea); v.e_acks = 8'(eack); v.e_done = 8'(edone);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [263:0] act, input logic [263:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Attempt-level reference: walks attempts, accumulating the cycle each request rises.
    function automatic void model(input vec_t v, input logic [31:0] prev_hdr,
                                  output logic [2:0] st, output logic [7:0] err,
                                  output logic [31:0] hdr, output int att, output int acks,
                                  output int dcyc);
        int r;
        int d;
        logic [7:0] ver, mt, p;
        st = 3'd0; err = 8'h00; hdr = prev_hdr; att = 0; acks = 0; dcyc = 0; r = 1;
        if (v.rtype == 2'd3) begin
            st = 3'd6; dcyc = 2;
            return;
        end
        for (int a = 0; a <= int'(MR); a++) begin
            att++;
            if (v.dly[a] == 8'hFF) begin
                if (a < int'(MR)) begin
                    r += TO + 1;
                    continue;
                end
                st = 3'd1; dcyc = r + TO + 1;
                return;
            end
            acks++;
            hdr = v.hdr[a];
            d   = int'(v.dly[a]);
            ver = hdr[31:24]; mt = hdr[23:16]; p = hdr[15:8];
            if (ver != 8'd1) st = 3'd2;
            else if (mt == 8'h7F && p == 8'h03) begin
                if (a < int'(MR)) begin
                    r += d + 2;
                    continue;
                end
                st = 3'd5;
            end
            else if (mt == 8'h7F) begin st = 3'd4; err = p; end
            else if (mt == 8'h01 + {6'b0, v.rtype}) st = 3'd0;
            else st = 3'd3;
            dcyc = r + d + 2;
            return;
        end
    endfunction

    // Called at a negedge; drives start, plays the responder, checks the outcome.
    task automatic run_txn(input vec_t v, input logic [2:0] es, input logic [7:0] ee,
                           input logic [31:0] eh, input int ea, input int eacks, input int edone,
                           input bit stray);
        int k, a, acks, rises;
        bit prev, got_done;
        logic [ML-1:0] exp_msg;
        exp_msg = {8'h01, 8'h81 + {6'b0, v.rtype}, v.p1, v.p2, v.pay};
        start = 1'b1; req_type = v.rtype; req_param1 = v.p1; req_param2 = v.p2; req_payload = v.pay;
        k = 0; a = -1; acks = 0; rises = 0; prev = 1'b0; got_done = 1'b0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            start = 1'b0; resp_valid_in = 1'b0;
            if (cyc == 1) begin
                req_type = 2'($urandom); req_param1 = 8'($urandom); req_param2 = 8'($urandom);
                req_payload = {7{$urandom}};
                chk("busy_after_start", 264'(busy), 264'(1));
            end
            if (init_req_out && !prev) begin
                a++; rises++; k = 0;
                chk("req_msg", 264'(auth_msg_init_out), 264'(exp_msg));
            end
            prev = init_req_out;
            if (Ack_out) begin
                acks++;
                chk("ack_drops_req", 264'({init_req_out, auth_msg_init_out}), '0);
            end
            if (init_req_out) begin
                k++;
                if (a >= 0 && a <= int'(MR) && int'(v.dly[a]) == k) begin
                    resp_valid_in = 1'b1;
                    auth_msg_resp_in = {v.hdr[a], {7{v.hdr[a]}}};
                end
            end
            if (stray && cyc == 3) begin
                start = 1'b1; req_type = 2'($urandom); req_param1 = 8'($urandom);
            end
            if (done) begin
                got_done = 1'b1;
                chk("done_cycle", 264'(cyc), 264'(edone));
                chk("status", 264'(status), 264'(es));
                chk("err_code", 264'(resp_err_code), 264'(ee));
                chk("resp_header", 264'(resp_header), 264'(eh));
                chk("resp_payload", 264'(resp_payload), 264'({7{eh}}));
                chk("attempts", 264'(rises), 264'(ea));
                chk("ack_pulses", 264'(acks), 264'(eacks));
                chk("busy_at_done", 264'(busy), 264'(0));
                break;
            end
        end
        chk("done_seen", 264'(got_done), 264'(1));
        @(negedge clk);
        start = 1'b0; resp_valid_in = 1'b0;
        chk("done_one_cycle", 264'(done), 264'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] last_hdr;
        logic [2:0]  es;
        logic [7:0]  ee;
        logic [31:0] eh;
        int ea, eacks, edone;
        bit saw;
        vec_t v;

        tbl[0] = mk(2'd0, 8'h00, 8'h00, '0, {8'd5, 8'hFF, 8'hFF}, {32'h01010001, 32'h0, 32'h0},
                    3'd0, 8'h00, 32'h01010001, 1, 1, 8);
        tbl[1] = mk(2'd2, 8'h02, 8'h00, {28{8'hA5}}, {8'd5, 8'hFF, 8'hFF}, {32'h02030000, 32'h0, 32'h0},
                    3'd2, 8'h00, 32'h02030000, 1, 1, 8);
        tbl[2] = mk(2'd2, 8'h01, 8'h00, {28{8'h3C}}, {8'd3, 8'd3, 8'd3},
                    {32'h017F0300, 32'h017F0300, 32'h01030000}, 3'd0, 8'h00, 32'h01030000, 3, 3, 16);
        tbl[3] = mk(2'd1, 8'h00, 8'h00, '0, {8'hFF, 8'hFF, 8'hFF}, {32'h0, 32'h0, 32'h0},
                    3'd1, 8'h00, 32'h01030000, 3, 0, 28);
        tbl[4] = mk(2'd1, 8'h00, 8'h00, '0, {8'd4, 8'hFF, 8'hFF}, {32'h017F0500, 32'h0, 32'h0},
                    3'd4, 8'h05, 32'h017F0500, 1, 1, 7);
        tbl[5] = mk(2'd3, 8'h11, 8'h22, '0, {8'd2, 8'hFF, 8'hFF}, {32'h01010000, 32'h0, 32'h0},
                    3'd6, 8'h00, 32'h017F0500, 0, 0, 2);
        tbl[6] = mk(2'd0, 8'h00, 8'h00, '0, {8'd2, 8'd2, 8'd2},
                    {32'h017F0300, 32'h017F0300, 32'h017F0300}, 3'd5, 8'h00, 32'h017F0300, 3, 3, 13);
        tbl[7] = mk(2'd0, 8'h00, 8'h00, '0, {8'd8, 8'hFF, 8'hFF}, {32'h01020000, 32'h0, 32'h0},
                    3'd3, 8'h00, 32'h01020000, 1, 1, 11);
        tbl[8] = mk(2'd1, 8'h04, 8'h07, {7{32'h12345678}}, {8'hFF, 8'd8, 8'hFF},
                    {32'h0, 32'h01020000, 32'h0}, 3'd0, 8'h00, 32'h01020000, 2, 1, 20);

        reset = 1'b1; start = 1'b0; req_type = '0; req_param1 = '0; req_param2 = '0;
        req_payload = '0; resp_valid_in = 1'b0; auth_msg_resp_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_ctrl", 264'({init_req_out, Ack_out, busy, done}), '0);
        chk("reset_msg", 264'(auth_msg_init_out), '0);
        chk("reset_status", 264'({status, resp_err_code, resp_header}), '0);
        chk("reset_payload", 264'(resp_payload), '0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_txn(tbl[i], tbl[i].e_status, tbl[i].e_err, tbl[i].e_hdr, int'(tbl[i].e_att),
                    int'(tbl[i].e_acks), int'(tbl[i].e_done), 1'b0);
        last_hdr = tbl[8].e_hdr;

        // A response while idle must be neither acknowledged nor captured.
        resp_valid_in = 1'b1;
        auth_msg_resp_in = {32'h01010001, {7{32'hDEADBEEF}}};
        @(negedge clk);
        chk("idle_resp_no_ack", 264'(Ack_out), 264'(0));
        @(negedge clk);
        resp_valid_in = 1'b0;
        chk("idle_resp_no_ack2", 264'(Ack_out), 264'(0));
        chk("idle_resp_no_capture", 264'(resp_header), 264'(last_hdr));
        chk("idle_not_busy", 264'(busy), 264'(0));

        // Reset while waiting for a response: outputs clear at once, no done afterwards.
        start = 1'b1; req_type = 2'd0; req_param1 = 8'h00; req_param2 = 8'h00; req_payload = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("wait_req_high", 264'(init_req_out), 264'(1));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_ctrl", 264'({init_req_out, busy, Ack_out, done}), '0);
        chk("async_reset_msg", 264'(auth_msg_init_out), '0);
        chk("async_reset_hdr", 264'({status, resp_header}), '0);
        @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || Ack_out || init_req_out) saw = 1'b1;
        end
        chk("no_activity_after_reset", 264'(saw), 264'(0));
        run_txn(tbl[0], tbl[0].e_status, tbl[0].e_err, tbl[0].e_hdr, int'(tbl[0].e_att),
                int'(tbl[0].e_acks), int'(tbl[0].e_done), 1'b0);
        last_hdr = tbl[0].e_hdr;

        for (int n = 0; n < 60; n++) begin
            v = '0;
            v.rtype = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            v.p1 = 8'($urandom); v.p2 = 8'($urandom); v.pay = {7{$urandom}};
            for (int a = 0; a <= int'(MR); a++) begin
                logic [7:0] ver, mt, p;
                v.dly[a] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(2, TO));
                ver = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
                case ($urandom_range(0, 4))
                    0, 1: mt = 8'h7F;
                    2:    mt = 8'h01 + {6'b0, v.rtype};
                    3:    mt = 8'($urandom_range(1, 3));
                    default: mt = 8'($urandom);
                endcase
                p = (mt == 8'h7F && $urandom_range(0, 1) == 1) ? 8'h03 : 8'($urandom);
                v.hdr[a] = {ver, mt, p, 8'($urandom)};
            end
            model(v, last_hdr, es, ee, eh, ea, eacks, edone);
            run_txn(v, es, ee, eh, ea, eacks, edone, (v.rtype != 2'd3) && ($urandom_range(0, 1) == 1));
            last_hdr = eh;
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
